// File: rtl/adder_response_checker.sv
// ----------------------------------------------------------------------------
// adder_response_checker
//
// Receiving end of the exhaustive stimulus sweep for the 2-bit ripple adder.
// Each accepted vector's adder outputs are compared against a golden sum;
// checked vectors and mismatches are counted, ascending sweep order is
// enforced and the first failing vector is captured.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               begin a sweep (honored in IDLE or DONE only)
//   vec_valid           operands/outputs below are valid this cycle
//   c_in,a1,a0,b1,b0    operands as applied to the adder
//   s1,s0,c_out         adder outputs for those operands
//   busy                sweep in progress (RUN)
//   done                sweep complete, held until next start
//   pass                valid with done: no mismatches and no order error
//   mismatch            one-cycle pulse after a failed compare
//   seq_err             sticky: a vector arrived out of order
//   err_count           mismatch count, saturating
//   checked_count       vectors accepted this sweep
//   first_fail_vec      {c_in,a1,a0,b1,b0} of the first mismatch
//   first_fail_valid    first_fail_vec holds a captured vector
// ----------------------------------------------------------------------------
module adder_response_checker #(
    parameter int NUM_VECTORS = 32,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    input  logic             c_in,
    input  logic             a1,
    input  logic             a0,
    input  logic             b1,
    input  logic             b0,
    input  logic             s1,
    input  logic             s0,
    input  logic             c_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic             seq_err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] checked_count,
    output logic [4:0]       first_fail_vec,
    output logic             first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic       start_ok;
    logic       accept;
    logic       last_vec;
    logic       fail;
    logic [4:0] vec_idx;
    logic [4:0] exp_idx;
    logic [2:0] exp_sum;
    logic [2:0] obs_sum;

    assign vec_idx  = {c_in, a1, a0, b1, b0};
    assign exp_idx  = 5'(checked_count);
    assign exp_sum  = 3'({a1, a0}) + 3'({b1, b0}) + 3'(c_in);
    assign obs_sum  = {c_out, s1, s0};
    assign fail     = (obs_sum != exp_sum);

    // A start in IDLE/DONE wins over a simultaneous vec_valid: that vector
    // belongs to no sweep and is dropped.
    assign start_ok = start && (state != RUN);
    assign accept   = vec_valid && (state == RUN);
    assign last_vec = accept && (checked_count == CNT_W'(NUM_VECTORS - 1));

    // Status outputs decode registered state only, so they carry no
    // combinational path from any input.
    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0) && !seq_err;

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is defaulted first so no path through the case leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = RUN;
            RUN:     if (last_vec) state_next = DONE;
            DONE:    if (start_ok) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch         <= 1'b0;
            seq_err          <= 1'b0;
            err_count        <= '0;
            checked_count    <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            if (start_ok) begin
                seq_err          <= 1'b0;
                err_count        <= '0;
                checked_count    <= '0;
                first_fail_vec   <= '0;
                first_fail_valid <= 1'b0;
            end else if (accept) begin
                checked_count <= checked_count + 1'b1;
                if (vec_idx != exp_idx) begin
                    seq_err <= 1'b1;
                end
                if (fail) begin
                    mismatch <= 1'b1;
                    if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (!first_fail_valid) begin
                        first_fail_vec   <= vec_idx;
                        first_fail_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
